timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter WD_MARGIN, default 16, is the watchdog slack in 5 kHz ticks added to the granted duration.
REQ-002 Port clk_sys  input  1  is the system clock (PLL GLA domain); all logic is clocked on its rising edge.
REQ-003 Port rst  input  1  is the synchronous, active-high reset.
REQ-004 Port tick_5k  input  1  is a one-clk_sys-wide enable pulse at 5 kHz from the clock divider.
REQ-005 Port req  input  4  carries one level request per requester; bit n belongs to requester n.
REQ-006 Port req_para  input  64  carries the requested durations in 5 kHz ticks; requester n uses bits [16n+15:16n].
REQ-007 Port timeup  input  1  is the completion level from the shared long timer.
REQ-008 Port start  output  1  is a one-cycle start pulse to the long timer.
REQ-009 Port timer_para  output  16  is the duration presented to the long timer.
REQ-010 Port grant  output  4  is a one-hot indication of the current owner.
REQ-011 Port done  output  4  carries a one-cycle completion pulse to the owner.
REQ-012 Port busy  output  1  is high whenever the state is not IDLE.
REQ-013 Port err  output  1  is a one-cycle watchdog-abort pulse.

Function
REQ-014 The states shall be IDLE, START, WAIT and DONE, encoded in a registered state machine.
REQ-015 In IDLE with req nonzero, the block shall select a requester round-robin, searching upward from the index after the last-served index and wrapping from 3 to 0.
REQ-016 In the selection cycle, the block shall register grant, latch that requester's req_para into timer_para, and move to START.
REQ-017 If the latched duration equals 0, the block shall go from IDLE directly to DONE, with no start pulse.
REQ-018 START shall last exactly one cycle with start=1, then move to WAIT; start shall be 0 in every other state.
REQ-019 The block shall register timeup every cycle; a rising edge seen in START or WAIT shall move the state to DONE on the next edge.
REQ-020 A timeup edge in IDLE or DONE shall be ignored.
REQ-021 DONE shall last one cycle, with done[owner]=1.
REQ-022 On the exit from DONE, grant shall clear, the last-served pointer shall update to the owner, and the state shall return to IDLE.
REQ-023 Deasserting req during START or WAIT shall not abort the grant; done shall still pulse.
REQ-024 timer_para shall stay constant from latch until the exit from DONE.
REQ-025 Changes on req_para after the latch shall be ignored.
REQ-026 Latency from a request in IDLE to the start pulse shall be 2 cycles.
REQ-027 Latency from the timeup edge to the done pulse shall be 2 cycles.
REQ-028 The minimum gap between consecutive grants shall be 1 IDLE cycle.
REQ-029 Outputs start, grant, done, busy and err shall all be registered.

Reset
REQ-030 While rst=1 at a clk_sys edge, the state shall go to IDLE, the last-served pointer to 3 (so requester 0 is served first), and the timeup history register to 0.
REQ-031 While rst=1, start, timer_para, grant, done, busy and err shall all be 0.
REQ-032 A reset in mid-operation shall discard the current grant with no done pulse.
REQ-033 After a mid-operation reset, arbitration shall resume on the first cycle with rst=0.

Configuration
REQ-034 With TIMER_ARB_WATCHDOG_EN defined, a 17-bit counter shall clear on entry to START and increment on each tick_5k in WAIT.
REQ-035 With TIMER_ARB_WATCHDOG_EN defined, when the counter exceeds timer_para+WD_MARGIN, the block shall enter DONE and pulse err together with done[owner].
REQ-036 With TIMER_ARB_WATCHDOG_EN undefined, the block shall have no counter, WAIT shall persist until a timeup edge, and err shall be tied to 0.

Verification
REQ-037 The bench shall cover: rst=1 for 3 cycles, then req=0001 with para0=10 -> start pulse 2 cycles later with timer_para=10 and grant=0001; timeup rising -> done=0001 2 cycles later; then busy=0.
REQ-038 The bench shall cover: req=1111 held across four transactions -> grants in order 0001, 0010, 0100, 1000, then 0001 again on the fifth.
REQ-039 The bench shall cover: req=0100 with para2=0 -> done=0100 with no start pulse, and busy high for 2 cycles.
REQ-040 The bench shall cover: rst=1 asserted during WAIT for requester 1 -> no done pulse, all outputs 0; req=0011 next -> grant=0001.
REQ-041 The bench shall cover: watchdog build with para=5, WD_MARGIN=16 and timeup held at 0 -> err and done pulse on the cycle after the 22nd tick_5k; in the non-watchdog build, err stays 0 and busy stays high.
REQ-042 The bench shall cover: req1 deasserted during WAIT -> done=0010 still pulses on the timeup edge.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one long timer among four requesters.
// Define TIMER_ARB_WATCHDOG_EN to add a tick_5k watchdog that aborts a stuck grant.
module timer_arbiter #(
  parameter int WD_MARGIN = 16
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        tick_5k,
  input  logic [3:0]  req,
  input  logic [63:0] req_para,
  input  logic        timeup,
  output logic        start,
  output logic [15:0] timer_para,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  last_r;
  logic [1:0]  owner_r;
  logic        timeup_r;
  logic [3:0]  grant_r;
  logic [15:0] timer_para_r;
  logic        start_r;
  logic [3:0]  done_r;
  logic        busy_r;
  logic        err_r;

  logic [2:0]  pick_s;
  logic        sel_valid_s;
  logic [1:0]  sel_idx_s;
  logic [15:0] sel_para_s;
  logic        rise_s;
  logic        expire_s;
  logic        abort_s;

  // Returns {found, index}; the offset-1 candidate is checked last so it wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Requester selection and timeup edge detection.
  always_comb begin
    pick_s      = rr_pick(req, last_r);
    sel_valid_s = pick_s[2];
    sel_idx_s   = pick_s[1:0];
    sel_para_s  = req_para[{sel_idx_s, 4'b0000} +: 16];
    rise_s      = timeup & ~timeup_r;
  end

`ifdef TIMER_ARB_WATCHDOG_EN
  logic [16:0] wd_cnt_r;
  logic [16:0] wd_limit_s;
  logic        wd_abort_r;

  assign wd_limit_s = {1'b0, timer_para_r} + 17'(WD_MARGIN);
  assign expire_s   = (state_r == WAIT) && ((wd_cnt_r + {16'd0, tick_5k}) > wd_limit_s);
  assign abort_s    = wd_abort_r;

  // Watchdog tick counter; held at zero outside WAIT so it starts clean after START.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wd_cnt_r <= 17'd0;
    end else if (state_r == WAIT) begin
      wd_cnt_r <= wd_cnt_r + {16'd0, tick_5k};
    end else begin
      wd_cnt_r <= 17'd0;
    end
  end

  // Remembers that DONE was reached by timeout; a real timeup edge takes priority.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wd_abort_r <= 1'b0;
    end else if (state_r == WAIT) begin
      wd_abort_r <= expire_s & ~rise_s;
    end else if (state_r == IDLE) begin
      wd_abort_r <= 1'b0;
    end
  end
`else
  logic unused_s;

  assign expire_s = 1'b0;
  assign abort_s  = 1'b0;
  assign unused_s = tick_5k | (WD_MARGIN == 0);
`endif

  // Arbitration FSM; start/done/err trail the state by one cycle, busy spans both.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r      <= IDLE;
      last_r       <= 2'd3;
      owner_r      <= 2'd0;
      timeup_r     <= 1'b0;
      grant_r      <= 4'b0000;
      timer_para_r <= 16'd0;
      start_r      <= 1'b0;
      done_r       <= 4'b0000;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      timeup_r <= timeup;
      start_r  <= (state_r == START);
      done_r   <= (state_r == DONE) ? grant_r : 4'b0000;
      err_r    <= (state_r == DONE) && abort_s;
      case (state_r)
        IDLE: begin
          if (sel_valid_s) begin
            grant_r      <= 4'b0001 << sel_idx_s;
            owner_r      <= sel_idx_s;
            timer_para_r <= sel_para_s;
            busy_r       <= 1'b1;
            state_r      <= (sel_para_s == 16'd0) ? DONE : START;
          end else begin
            busy_r <= 1'b0;
          end
        end
        START: begin
          busy_r  <= 1'b1;
          state_r <= rise_s ? DONE : WAIT;
        end
        WAIT: begin
          busy_r  <= 1'b1;
          state_r <= (rise_s || expire_s) ? DONE : WAIT;
        end
        DONE: begin
          busy_r  <= 1'b1;
          grant_r <= 4'b0000;
          last_r  <= owner_r;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          grant_r <= 4'b0000;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign start      = start_r;
  assign timer_para = timer_para_r;
  assign grant      = grant_r;
  assign done       = done_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: stimulus queues expected start/done
// pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_timer_arbiter;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        tick_5k = 1'b0;
  logic        timeup = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] req_para = 64'd0;
  logic        start;
  logic [15:0] timer_para;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;

  logic [19:0] exp_start_q[$];
  logic [4:0]  exp_done_q[$];

  timer_arbiter #(.WD_MARGIN(16)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .tick_5k    (tick_5k),
    .req        (req),
    .req_para   (req_para),
    .timeup     (timeup),
    .start      (start),
    .timer_para (timer_para),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void exp_start(input logic [3:0] g, input logic [15:0] p);
    exp_start_q.push_back({g, p});
  endfunction

  function automatic void exp_done(input logic [3:0] g, input logic e);
    exp_done_q.push_back({g, e});
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_para(input int n, input logic [15:0] p);
    req_para[16*n +: 16] = p;
  endtask

  // Waits (bounded) for the start pulse; request was applied just before the call.
  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!start && n < 16);
    check(name, 32'(n), 32'd2);
  endtask

  // From the start pulse: let the timer run, raise timeup, expect done two cycles on.
  task automatic finish_txn(input logic [3:0] g, input logic [15:0] p);
    step();
    step();
    timeup = 1'b1;
    step();
    check("busy_before_done", 32'(busy), 32'd1);
    step();
    check("done_latency", 32'(done), 32'(g));
    check("para_held", 32'(timer_para), 32'(p));
    timeup = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk_sys) begin
    logic [19:0] es;
    logic [4:0]  ed;
    if (start) begin
      if (exp_start_q.size() == 0) begin
        check("sb_start_unexpected", 32'(start), 32'd0);
      end else begin
        es = exp_start_q.pop_front();
        check("sb_start_grant", 32'(grant), 32'(es[19:16]));
        check("sb_start_para", 32'(timer_para), 32'(es[15:0]));
      end
    end
    if (done != 4'b0000) begin
      if (exp_done_q.size() == 0) begin
        check("sb_done_unexpected", 32'(done), 32'd0);
      end else begin
        ed = exp_done_q.pop_front();
        check("sb_done", 32'(done), 32'(ed[4:1]));
        check("sb_err", 32'(err), 32'(ed[0]));
      end
    end else if (err) begin
      check("sb_err_alone", 32'(err), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    // Reset held for three edges
    rst = 1'b1;
    repeat (3) step();
    check("rst_start", 32'(start), 32'd0);
    check("rst_para", 32'(timer_para), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Single request from requester 0
    rst = 1'b0;
    set_para(0, 16'd10);
    req = 4'b0001;
    exp_start(4'b0001, 16'd10);
    exp_done(4'b0001, 1'b0);
    wait_start("t1_start_latency");
    check("t1_para", 32'(timer_para), 32'd10);
    check("t1_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    finish_txn(4'b0001, 16'd10);
    step();
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_grant_clear", 32'(grant), 32'd0);

    // All four requesting: rotation from a fresh reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) set_para(n, 16'(3 + n));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0]  g;
      logic [15:0] p;
      g = 4'b0001 << (i % 4);
      p = 16'(3 + (i % 4));
      exp_start(g, p);
      exp_done(g, 1'b0);
      wait_start("t2_start_latency");
      check("t2_grant_order", 32'(grant), 32'(g));
      finish_txn(g, p);
    end
    req = 4'b0000;
    step();
    check("t2_busy_idle", 32'(busy), 32'd0);

    // Zero duration: straight to DONE, no start pulse
    set_para(2, 16'd0);
    req = 4'b0100;
    exp_done(4'b0100, 1'b0);
    step();
    check("t3_busy_1", 32'(busy), 32'd1);
    check("t3_grant", 32'(grant), 32'h4);
    check("t3_no_start_1", 32'(start), 32'd0);
    step();
    check("t3_done", 32'(done), 32'h4);
    check("t3_busy_2", 32'(busy), 32'd1);
    check("t3_no_start_2", 32'(start), 32'd0);
    req = 4'b0000;
    step();
    check("t3_busy_end", 32'(busy), 32'd0);

    // Reset during WAIT for requester 1 discards the grant
    set_para(1, 16'd7);
    req = 4'b0010;
    exp_start(4'b0010, 16'd7);
    wait_start("t4_start_latency");
    step();
    step();
    rst = 1'b1;
    step();
    check("t4_rst_start", 32'(start), 32'd0);
    check("t4_rst_grant", 32'(grant), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_para", 32'(timer_para), 32'd0);
    step();
    rst = 1'b0;
    set_para(0, 16'd9);
    req = 4'b0011;
    exp_start(4'b0001, 16'd9);
    exp_done(4'b0001, 1'b0);
    wait_start("t4_resume_latency");
    check("t4_grant_after_rst", 32'(grant), 32'h1);
    req = 4'b0000;
    finish_txn(4'b0001, 16'd9);
    step();

    // Requester 1 drops req in WAIT; para bus changes are ignored
    set_para(1, 16'd4);
    req = 4'b0010;
    exp_start(4'b0010, 16'd4);
    exp_done(4'b0010, 1'b0);
    wait_start("t5_start_latency");
    req = 4'b0000;
    set_para(1, 16'hFFFF);
    finish_txn(4'b0010, 16'd4);
    step();

    // Timer never completes: watchdog abort or indefinite wait
    set_para(0, 16'd5);
    req = 4'b0001;
    exp_start(4'b0001, 16'd5);
`ifdef TIMER_ARB_WATCHDOG_EN
    exp_done(4'b0001, 1'b1);
    wait_start("t6_start_latency");
    req = 4'b0000;
    for (int t = 1; t <= 22; t++) begin
      tick_5k = 1'b1;
      step();
      tick_5k = 1'b0;
      if (t < 22) begin
        step();
        step();
      end
    end
    step();
    check("t6_wd_done", 32'(done), 32'h1);
    check("t6_wd_err", 32'(err), 32'd1);
    step();
    check("t6_wd_busy_end", 32'(busy), 32'd0);
`else
    exp_done(4'b0001, 1'b0);
    wait_start("t6_start_latency");
    req = 4'b0000;
    for (int t = 1; t <= 30; t++) begin
      tick_5k = 1'b1;
      step();
      tick_5k = 1'b0;
      step();
      step();
    end
    check("t6_err_low", 32'(err), 32'd0);
    check("t6_busy_held", 32'(busy), 32'd1);
    check("t6_no_done", 32'(done), 32'd0);
    finish_txn(4'b0001, 16'd5);
    step();
`endif

    step();
    step();
    check("sb_start_drained", 32'(exp_start_q.size()), 32'd0);
    check("sb_done_drained", 32'(exp_done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
